// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared mode encodings and helpers for the DLX immediate
//               extension stage.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ZERO  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SIGN  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER = 3'd2;
    localparam logic [MODE_W-1:0] MODE_JUMP  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BYTE  = 3'd4;

    // Encodings above MODE_BYTE are reserved and flagged as errors.
    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return (mode <= MODE_BYTE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_ext_comb.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_comb
// Description : Combinational immediate extender (zero/sign/upper/jump/byte)
//               with illegal-mode flag.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int JMP_W = 26,
    parameter int OUT_W = 32
) (
    input  logic [JMP_W-1:0]  imm_in,
    input  logic [MODE_W-1:0] mode,
    output logic [OUT_W-1:0]  value,
    output logic              err
);

    // Select the extension rule; illegal modes produce a zero value.
    always_comb begin
        value = '0;
        err   = !is_legal_mode(mode);
        case (mode)
            MODE_ZERO:  value = {{(OUT_W-IN_W){1'b0}}, imm_in[IN_W-1:0]};
            MODE_SIGN:  value = {{(OUT_W-IN_W){imm_in[IN_W-1]}}, imm_in[IN_W-1:0]};
            MODE_UPPER: value = {imm_in[IN_W-1:0], {(OUT_W-IN_W){1'b0}}};
            // Signed cast handles OUT_W == JMP_W without a zero-width replication.
            MODE_JUMP:  value = OUT_W'($signed(imm_in));
            MODE_BYTE:  value = {{(OUT_W-8){imm_in[7]}}, imm_in[7:0]};
            default:    value = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_stage
// Description : Pipelined immediate-extension stage between decode and
//               execute. Extends on entry and stores results in a small
//               skid buffer with valid/ready handshakes and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int JMP_W = 26,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [JMP_W-1:0]  imm_in,
    input  logic [MODE_W-1:0] mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  imm_out,
    output logic              mode_err
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

    logic [OUT_W-1:0]   w_ext_value;
    logic               w_ext_err;
    logic               w_push;
    logic               w_pop;

    logic [OUT_W-1:0]   r_data [DEPTH];
    logic               r_err  [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    // Last popped entry, presented while the buffer is empty.
    logic [OUT_W-1:0]   r_hold_value;
    logic               r_hold_err;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .JMP_W (JMP_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .imm_in (imm_in),
        .mode   (mode),
        .value  (w_ext_value),
        .err    (w_ext_err)
    );

    // Handshake and output views derived from registered state only.
    always_comb begin
        in_ready  = (r_count < c_depth_cnt);
        out_valid = (r_count != '0);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
        imm_out   = out_valid ? r_data[r_rd_ptr] : r_hold_value;
        mode_err  = out_valid ? r_err[r_rd_ptr]  : r_hold_err;
    end

    // Buffer storage, pointers and occupancy; reset > flush > push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold_value <= '0;
            r_hold_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_err[i]  <= 1'b0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_ext_value;
                r_err[r_wr_ptr]  <= w_ext_err;
                r_wr_ptr         <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_hold_value <= r_data[r_rd_ptr];
                r_hold_err   <= r_err[r_rd_ptr];
                r_rd_ptr     <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire
